six_pin_to_nine_segment: RTL and testbench

SIX_PIN_TO_NINE_SEGMENT -- requirements
Module: six_pin_to_nine_segment

---
 rtl/six_pin_to_nine_segment.sv | 169 ++++++++++++++++
 tb/tb_six_pin_to_nine_segment.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/six_pin_to_nine_segment.sv
// six_pin_to_nine_segment
// Decodes a multiplexed 3x3 LED die display driven on three anode rows
// (active-high) and three cathode columns (active-low) back into a 9-bit
// pattern and a die value. Samples are taken on scan ticks; every three
// samples form a frame. A new pattern is only shown once two consecutive
// frames agree, so glitches and partially updated frames are ignored.
// Optional build macro: NINE_SEG_INPUT_SYNC_EN adds a two-flop synchronizer
// on rows/cols and delays enable by the same two cycles.
module six_pin_to_nine_segment (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] rows,
    input  logic [2:0] cols,
    output logic [8:0] segments,
    output logic [2:0] value,
    output logic       pattern_ok,
    output logic       frame_done,
    output logic       update
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    logic [2:0] rows_in;
    logic [2:0] cols_in;
    logic       en_in;

`ifdef NINE_SEG_INPUT_SYNC_EN
    logic [2:0] rows_s1_q, rows_s2_q;
    logic [2:0] cols_s1_q, cols_s2_q;
    logic       en_s1_q, en_s2_q;

    // Two-stage synchronizer for the pins, with enable delayed to match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_s1_q <= '0;
            rows_s2_q <= '0;
            cols_s1_q <= '0;
            cols_s2_q <= '0;
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
        end else begin
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
            cols_s1_q <= cols;
            cols_s2_q <= cols_s1_q;
            en_s1_q   <= enable;
            en_s2_q   <= en_s1_q;
        end
    end

    assign rows_in = rows_s2_q;
    assign cols_in = cols_s2_q;
    assign en_in   = en_s2_q;
`else
    assign rows_in = rows;
    assign cols_in = cols;
    assign en_in   = enable;
`endif

    phase_e     phase_q, phase_d;
    logic [8:0] acc_q, acc_d;
    logic [8:0] prev_frame_q, prev_frame_d;
    logic [8:0] segments_q, segments_d;
    logic [2:0] value_q, value_d;
    logic       pattern_ok_q, pattern_ok_d;
    logic       frame_done_q, frame_done_d;
    logic       update_q, update_d;

    logic [8:0] sample;
    logic [8:0] frame_value;
    logic [3:0] decoded;

    // Map a die pattern to {pattern_ok, value}; unknown patterns give {0, 0}.
    function automatic logic [3:0] decode_die(input logic [8:0] p);
        case (p)
            9'b000000000: decode_die = 4'b1_000;
            9'b000010000: decode_die = 4'b1_001;
            9'b100000001: decode_die = 4'b1_010;
            9'b100010001: decode_die = 4'b1_011;
            9'b101000101: decode_die = 4'b1_100;
            9'b101010101: decode_die = 4'b1_101;
            9'b111000111: decode_die = 4'b1_110;
            9'b111010111: decode_die = 4'b1_111;
            default:      decode_die = 4'b0_000;
        endcase
    endfunction

    // Lit cells of the current sample, accumulated frame, and next-state logic.
    always_comb begin
        sample = {rows_in[2] & ~cols_in[2], rows_in[2] & ~cols_in[1], rows_in[2] & ~cols_in[0],
                  rows_in[1] & ~cols_in[2], rows_in[1] & ~cols_in[1], rows_in[1] & ~cols_in[0],
                  rows_in[0] & ~cols_in[2], rows_in[0] & ~cols_in[1], rows_in[0] & ~cols_in[0]};
        frame_value  = acc_q | sample;
        decoded      = decode_die(frame_value);

        phase_d      = phase_q;
        acc_d        = acc_q;
        prev_frame_d = prev_frame_q;
        segments_d   = segments_q;
        value_d      = value_q;
        pattern_ok_d = pattern_ok_q;
        frame_done_d = 1'b0;
        update_d     = 1'b0;

        if (en_in) begin
            case (phase_q)
                PH0: begin
                    acc_d   = frame_value;
                    phase_d = PH1;
                end
                PH1: begin
                    acc_d   = frame_value;
                    phase_d = PH2;
                end
                PH2: begin
                    acc_d        = '0;
                    phase_d      = PH0;
                    frame_done_d = 1'b1;
                    prev_frame_d = frame_value;
                    if ((frame_value == prev_frame_q) && (frame_value != segments_q)) begin
                        segments_d   = frame_value;
                        pattern_ok_d = decoded[3];
                        value_d      = decoded[2:0];
                        update_d     = 1'b1;
                    end
                end
                default: begin
                    acc_d   = '0;
                    phase_d = PH0;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= PH0;
            acc_q        <= '0;
            prev_frame_q <= '0;
            segments_q   <= '0;
            value_q      <= '0;
            pattern_ok_q <= 1'b1;
            frame_done_q <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            prev_frame_q <= prev_frame_d;
            segments_q   <= segments_d;
            value_q      <= value_d;
            pattern_ok_q <= pattern_ok_d;
            frame_done_q <= frame_done_d;
            update_q     <= update_d;
        end
    end

    assign segments   = segments_q;
    assign value      = value_q;
    assign pattern_ok = pattern_ok_q;
    assign frame_done = frame_done_q;
    assign update     = update_q;

endmodule

// File: tb/tb_six_pin_to_nine_segment.sv
// tb_six_pin_to_nine_segment
// Scoreboard bench: each driven cycle pushes the expected outputs from a
// small behavioural model of the decoder; they are popped and compared once
// the clock edge has produced the DUT outputs. Targeted scenario checks
// against fixed constants follow each scenario.
module tb_six_pin_to_nine_segment;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] rows;
   logic [2:0] cols;
   logic [8:0] segments;
   logic [2:0] value;
   logic       pattern_ok;
   logic       frame_done;
   logic       update;

   six_pin_to_nine_segment dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .rows       (rows),
      .cols       (cols),
      .segments   (segments),
      .value      (value),
      .pattern_ok (pattern_ok),
      .frame_done (frame_done),
      .update     (update)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] seg;
      logic [2:0] val;
      logic       ok;
      logic       fd;
      logic       upd;
   } expT;

   expT        scoreQ[$];
   int         testsRun = 0;
   int         testsFailed = 0;
   int         updCount = 0;
   int         fdCount = 0;

   int         mPhase;
   logic [8:0] mAcc;
   logic [8:0] mPrev;
   logic [8:0] mSeg;
   logic [2:0] mVal;
   logic       mOk;

   task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] litCells(input logic [2:0] r, input logic [2:0] c);
      logic [8:0] s;
      s = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (r[2-i] && !c[2-j]) s[8-(3*i+j)] = 1'b1;
      return s;
   endfunction

   function automatic int dieIndex(input logic [8:0] p);
      logic [8:0] dieTable [8];
      dieTable = '{9'b000000000, 9'b000010000, 9'b100000001, 9'b100010001,
                   9'b101000101, 9'b101010101, 9'b111000111, 9'b111010111};
      for (int i = 0; i < 8; i++)
         if (dieTable[i] == p) return i;
      return -1;
   endfunction

   task automatic resetModel();
      mPhase = 0;
      mAcc   = '0;
      mPrev  = '0;
      mSeg   = '0;
      mVal   = '0;
      mOk    = 1'b1;
   endtask

   // Called at a negedge; drives one cycle, checks it after the posedge, returns at the next negedge.
   task automatic applyStimulus(input logic en, input logic [2:0] r, input logic [2:0] c, input string tag);
      expT        e;
      logic [8:0] s;
      logic [8:0] frame;
      int         d;
      enable = en;
      rows   = r;
      cols   = c;
      e.fd   = 1'b0;
      e.upd  = 1'b0;
      if (en) begin
         s = litCells(r, c);
         if (mPhase == 2) begin
            frame = mAcc | s;
            e.fd  = 1'b1;
            if (frame == mPrev && frame != mSeg) begin
               e.upd = 1'b1;
               mSeg  = frame;
               d     = dieIndex(frame);
               if (d >= 0) begin
                  mVal = 3'(d);
                  mOk  = 1'b1;
               end else begin
                  mVal = 3'd0;
                  mOk  = 1'b0;
               end
            end
            mPrev  = frame;
            mAcc   = '0;
            mPhase = 0;
         end else begin
            mAcc   = mAcc | s;
            mPhase = mPhase + 1;
         end
      end
      e.seg = mSeg;
      e.val = mVal;
      e.ok  = mOk;
      scoreQ.push_back(e);
      @(posedge clk);
      #2;
      e = scoreQ.pop_front();
      checkOutput({tag, "_seg"}, segments, e.seg);
      checkOutput({tag, "_val"}, {6'b0, value}, {6'b0, e.val});
      checkOutput({tag, "_ok"}, {8'b0, pattern_ok}, {8'b0, e.ok});
      checkOutput({tag, "_fd"}, {8'b0, frame_done}, {8'b0, e.fd});
      checkOutput({tag, "_upd"}, {8'b0, update}, {8'b0, e.upd});
      if (update) updCount++;
      if (frame_done) fdCount++;
      @(negedge clk);
   endtask

   // Asserts reset between edges and checks that outputs clear without a clock.
   task automatic doReset(input string tag);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      checkOutput({tag, "_seg"}, segments, 9'b000000000);
      checkOutput({tag, "_val"}, {6'b0, value}, 9'd0);
      checkOutput({tag, "_ok"}, {8'b0, pattern_ok}, 9'd1);
      checkOutput({tag, "_fd"}, {8'b0, frame_done}, 9'd0);
      checkOutput({tag, "_upd"}, {8'b0, update}, 9'd0);
      resetModel();
      scoreQ.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [2:0] rows3 [3] = '{3'b100, 3'b010, 3'b001};
   logic [2:0] cols3 [3] = '{3'b011, 3'b101, 3'b110};
   logic [2:0] cols5 [3] = '{3'b010, 3'b101, 3'b010};
   logic [2:0] cols7 [3] = '{3'b000, 3'b101, 3'b000};

   // Scenario sequence.
   initial begin
      int updCycle;
      int foundIdx;
      reset  = 1'b1;
      enable = 1'b0;
      rows   = 3'b000;
      cols   = 3'b111;
      resetModel();
      @(negedge clk);
      doReset("reset");

      // Static centre dot, scan tick every 4th cycle.
      updCount = 0;
      for (int f = 0; f < 6; f++) begin
         applyStimulus(1'b1, 3'b010, 3'b101, "static1");
         repeat (3) applyStimulus(1'b0, 3'b010, 3'b101, "static1");
      end
      checkOutput("static1_final_seg", segments, 9'b000010000);
      checkOutput("static1_final_val", {6'b0, value}, 9'd1);
      checkOutput("static1_final_ok", {8'b0, pattern_ok}, 9'd1);
      checkOutput("static1_upd_count", 9'(updCount), 9'd1);

      // Multiplexed value 3, stream starting mid-sequence, idle cycle between ticks.
      fdCount = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, rows3[(k+1)%3], cols3[(k+1)%3], "mux3");
         applyStimulus(1'b0, rows3[(k+1)%3], cols3[(k+1)%3], "mux3");
      end
      checkOutput("mux3_final_seg", segments, 9'b100010001);
      checkOutput("mux3_final_val", {6'b0, value}, 9'd3);
      checkOutput("mux3_fd_count", 9'(fdCount), 9'd4);

      // Value 5 stream, then one blanked frame, then the stream resumes.
      for (int k = 0; k < 6; k++)
         applyStimulus(1'b1, rows3[k%3], cols5[k%3], "val5");
      checkOutput("val5_seg", segments, 9'b101010101);
      updCount = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 3'b000, cols5[k%3], "filter");
         checkOutput("filter_hold", segments, 9'b101010101);
      end
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, rows3[k%3], cols5[k%3], "filter");
         checkOutput("filter_hold", segments, 9'b101010101);
      end
      checkOutput("filter_upd_count", 9'(updCount), 9'd0);

      // Unrecognised static pattern.
      for (int k = 0; k < 6; k++)
         applyStimulus(1'b1, 3'b110, 3'b011, "unrec");
      checkOutput("unrec_seg", segments, 9'b100100000);
      checkOutput("unrec_val", {6'b0, value}, 9'd0);
      checkOutput("unrec_ok", {8'b0, pattern_ok}, 9'd0);

      // Enable held high with static value 4.
      fdCount  = 0;
      updCycle = -1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         applyStimulus(1'b1, 3'b101, 3'b010, "b2b");
         checkOutput("b2b_fd_phase", {8'b0, frame_done}, (cyc % 3 == 0) ? 9'd1 : 9'd0);
         if (update && updCycle < 0) updCycle = cyc;
      end
      checkOutput("b2b_upd_cycle", 9'(updCycle), 9'd6);
      checkOutput("b2b_fd_count", 9'(fdCount), 9'd4);
      checkOutput("b2b_val", {6'b0, value}, 9'd4);

      // Enable low: pins wiggle but nothing moves.
      fdCount  = 0;
      updCount = 0;
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "idle");
      checkOutput("idle_seg", segments, 9'b101000101);
      checkOutput("idle_pulses", 9'(fdCount + updCount), 9'd0);

      // Value 7 stream interrupted by reset after two ticks.
      for (int k = 0; k < 2; k++)
         applyStimulus(1'b1, rows3[k], cols7[k], "pre_rst");
      doReset("midrst");
      foundIdx = -1;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b1, rows3[(k-1)%3], cols7[(k-1)%3], "val7");
         if (value == 3'd7 && foundIdx < 0) foundIdx = k;
      end
      checkOutput("rst_latency", 9'(foundIdx), 9'd6);
      checkOutput("val7_seg", segments, 9'b111010111);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
